// File: rtl/periph_clk_div_pkg.sv
// Shared types and helpers for the peripheral clock divider.
package periph_clk_div_pkg;

    localparam int MinDiv  = 2;
    localparam int MaxChW  = 4;
    localparam int MaxDivW = 32;

    typedef struct packed {
        logic [MaxChW-1:0]  ch;
        logic [MaxDivW-1:0] div;
        logic               en;
    } cfg_t;

    // Number of high cycles in one period; odd ratios get the extra cycle high.
    function automatic logic [MaxDivW-1:0] half_period(input logic [MaxDivW-1:0] div);
        return (div + 32'd1) >> 1;
    endfunction

endpackage

// File: rtl/periph_clk_div_channel.sv
// One divider channel: counter, shadow (pending) ratio registers and output registers.
// Optional phase-align input is present when PERIPH_CLK_DIVIDER_SYNC_EN is defined.
module periph_clk_div_channel
    import periph_clk_div_pkg::*;
#(
    parameter int DivWidth   = 16,
    parameter int DefaultDiv = 50,
    parameter bit DefaultEn  = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
`ifdef PERIPH_CLK_DIVIDER_SYNC_EN
    input  logic                sync,
`endif
    input  logic                wr,
    input  logic [DivWidth-1:0] wr_div,
    input  logic                wr_en,
    output logic                pend,
    output logic                div_clk,
    output logic                tick,
    output logic                active
);

    logic [DivWidth-1:0] cnt_q;
    logic [DivWidth-1:0] div_q;
    logic [DivWidth-1:0] pend_div_q;
    logic                en_q;
    logic                pend_q;
    logic                pend_en_q;
    logic                out_q;
    logic                tick_q;
    logic                wrap;

    assign active = en_q && (div_q >= DivWidth'(MinDiv));
    assign wrap   = active && (cnt_q == div_q - DivWidth'(1));

    always_ff @(posedge clk) begin
        if (wr) begin
            pend_div_q <= wr_div;
            pend_en_q  <= wr_en;
        end
    end

    // Shadow values only land on a period boundary so the running period never shortens.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            div_q  <= DivWidth'(DefaultDiv);
            en_q   <= DefaultEn;
            pend_q <= 1'b0;
            out_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            if (wr) begin
                pend_q <= 1'b1;
            end
            if (active) begin
                tick_q <= wrap;
                out_q  <= (MaxDivW'(cnt_q) < half_period(MaxDivW'(div_q)));
                if (wrap) begin
                    cnt_q <= '0;
                    if (pend_q) begin
                        div_q  <= pend_div_q;
                        en_q   <= pend_en_q;
                        pend_q <= 1'b0;
                    end
                end else begin
                    cnt_q <= cnt_q + DivWidth'(1);
                end
`ifdef PERIPH_CLK_DIVIDER_SYNC_EN
                if (sync) begin
                    cnt_q <= '0;
                end
`endif
            end else begin
                cnt_q  <= '0;
                out_q  <= 1'b0;
                tick_q <= 1'b0;
                if (pend_q) begin
                    div_q  <= pend_div_q;
                    en_q   <= pend_en_q;
                    pend_q <= 1'b0;
                end
            end
        end
    end

    assign pend    = pend_q;
    assign div_clk = out_q;
    assign tick    = tick_q;

endmodule

// File: rtl/periph_clk_divider.sv
// Multi-channel peripheral clock / tick divider with a valid/ready ratio config port.
// Define PERIPH_CLK_DIVIDER_SYNC_EN to add sync_i, which phase-aligns all active channels.
module periph_clk_divider
    import periph_clk_div_pkg::*;
#(
    parameter  int NumCh      = 2,
    parameter  int DivWidth   = 16,
    parameter  int DefaultDiv = 50,
    parameter  bit DefaultEn  = 1'b1,
    localparam int ChW        = (NumCh > 1) ? $clog2(NumCh) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
`ifdef PERIPH_CLK_DIVIDER_SYNC_EN
    input  logic                sync_i,
`endif
    input  logic                cfg_valid_i,
    output logic                cfg_ready_o,
    input  logic [ChW-1:0]      cfg_ch_i,
    input  logic [DivWidth-1:0] cfg_div_i,
    input  logic                cfg_en_i,
    output logic                cfg_err_o,
    output logic [NumCh-1:0]    div_clk_o,
    output logic [NumCh-1:0]    tick_o,
    output logic [NumCh-1:0]    active_o
);

    cfg_t             cfg;
    logic [NumCh-1:0] sel;
    logic [NumCh-1:0] pend;
    logic [NumCh-1:0] wr;
    logic [NumCh-1:0] ch_active;
    logic             oor;
    logic             illegal;
    logic             xfer;
    logic             err_q;

    always_comb begin
        cfg     = '0;
        cfg.ch  = MaxChW'(cfg_ch_i);
        cfg.div = MaxDivW'(cfg_div_i);
        cfg.en  = cfg_en_i;
    end

    always_comb begin
        sel = '0;
        for (int i = 0; i < NumCh; i++) begin
            sel[i] = (cfg.ch == MaxChW'(i));
        end
    end

    // A channel index that selects nothing is out of range: always ready, always rejected.
    assign oor         = ~|sel;
    assign illegal     = cfg.en && (cfg.div < MaxDivW'(MinDiv));
    assign cfg_ready_o = oor || ~|(sel & pend);
    assign xfer        = cfg_valid_i && cfg_ready_o;
    assign wr          = (xfer && !oor && !illegal) ? sel : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= xfer && (oor || illegal);
        end
    end

    assign cfg_err_o = err_q;

    for (genvar g = 0; g < NumCh; g++) begin : g_ch
        periph_clk_div_channel #(
            .DivWidth  (DivWidth),
            .DefaultDiv(DefaultDiv),
            .DefaultEn (DefaultEn)
        ) u_ch (
            .clk    (clk_i),
            .rst    (rst_i),
`ifdef PERIPH_CLK_DIVIDER_SYNC_EN
            .sync   (sync_i),
`endif
            .wr     (wr[g]),
            .wr_div (cfg_div_i),
            .wr_en  (cfg_en_i),
            .pend   (pend[g]),
            .div_clk(div_clk_o[g]),
            .tick   (tick_o[g]),
            .active (ch_active[g])
        );
    end

    assign active_o = ch_active & {NumCh{~rst_i}};

endmodule

// File: tb/tb_periph_clk_divider.sv
// Self-checking bench for periph_clk_divider: directed sequences, a config table and random traffic.
module tb_periph_clk_divider;

    localparam int NumCh      = 3;
    localparam int DivWidth   = 16;
    localparam int DefaultDiv = 50;

    logic                clk       = 1'b0;
    logic                rst       = 1'b1;
    logic                cfg_valid = 1'b0;
    logic                cfg_en    = 1'b0;
    logic [1:0]          cfg_ch    = '0;
    logic [DivWidth-1:0] cfg_div   = '0;
    logic                cfg_ready;
    logic                cfg_err;
    logic [NumCh-1:0]    div_clk;
    logic [NumCh-1:0]    tick;
    logic [NumCh-1:0]    active;
`ifdef PERIPH_CLK_DIVIDER_SYNC_EN
    logic                sync      = 1'b0;
`endif

    always #5 clk = ~clk;

    periph_clk_divider #(
        .NumCh     (NumCh),
        .DivWidth  (DivWidth),
        .DefaultDiv(DefaultDiv),
        .DefaultEn (1'b1)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
`ifdef PERIPH_CLK_DIVIDER_SYNC_EN
        .sync_i     (sync),
`endif
        .cfg_valid_i(cfg_valid),
        .cfg_ready_o(cfg_ready),
        .cfg_ch_i   (cfg_ch),
        .cfg_div_i  (cfg_div),
        .cfg_en_i   (cfg_en),
        .cfg_err_o  (cfg_err),
        .div_clk_o  (div_clk),
        .tick_o     (tick),
        .active_o   (active)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: each channel's phase is (cycle - base) mod N.
    int               m_base [NumCh];
    int               m_n    [NumCh];
    int               m_pn   [NumCh];
    bit               m_en   [NumCh];
    bit               m_pend [NumCh];
    bit               m_pe   [NumCh];
    bit [NumCh-1:0]   m_out;
    bit [NumCh-1:0]   m_tick;
    bit               m_err;

    int trk_ch = 0, trk_len = 0, trk_hi = -1, trk_lo = -1, trk_min = 1000;
    bit trk_prev, trk_first;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic bit m_act(input int i);
        return m_en[i] && (m_n[i] >= 2);
    endfunction

    function automatic logic [NumCh-1:0] act_vec();
        logic [NumCh-1:0] v;
        for (int i = 0; i < NumCh; i++) v[i] = m_act(i);
        return v;
    endfunction

    function automatic logic exp_ready();
        int c;
        c = int'(cfg_ch);
        if (c >= NumCh) return 1'b1;
        return !m_pend[c];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NumCh; i++) begin
            m_base[i] = cyc;
            m_n[i]    = DefaultDiv;
            m_en[i]   = 1'b1;
            m_pend[i] = 1'b0;
        end
        m_out  = '0;
        m_tick = '0;
        m_err  = 1'b0;
    endtask

    task automatic model_step();
        int c, ph;
        bit oor, bad, xfer, was_act;
        c   = int'(cfg_ch);
        oor = (c >= NumCh);
        if (oor) xfer = cfg_valid;
        else     xfer = cfg_valid && !m_pend[c];
        bad = oor || ((int'(cfg_div) < 2) && cfg_en);
        for (int i = 0; i < NumCh; i++) begin
            was_act = m_act(i);
            if (was_act) begin
                ph        = (cyc - m_base[i]) % m_n[i];
                m_out[i]  = (ph < (m_n[i] + 1) / 2);
                m_tick[i] = (ph == m_n[i] - 1);
            end else begin
                m_out[i]  = 1'b0;
                m_tick[i] = 1'b0;
            end
            if (m_pend[i] && (!was_act || m_tick[i])) begin
                m_n[i]    = m_pn[i];
                m_en[i]   = m_pe[i];
                m_pend[i] = 1'b0;
                m_base[i] = cyc + 1;
            end
`ifdef PERIPH_CLK_DIVIDER_SYNC_EN
            if (sync && was_act) m_base[i] = cyc + 1;
`endif
        end
        if (xfer && !bad) begin
            m_pend[c] = 1'b1;
            m_pn[c]   = int'(cfg_div);
            m_pe[c]   = cfg_en;
        end
        m_err = xfer && bad;
        cyc++;
    endtask

    task automatic trk_reset(input int ch);
        trk_ch = ch; trk_len = 0; trk_first = 1'b1; trk_prev = div_clk[ch];
        trk_hi = -1; trk_lo = -1; trk_min = 1000;
    endtask

    task automatic track();
        if (div_clk[trk_ch] == trk_prev) begin
            trk_len++;
        end else begin
            if (!trk_first) begin
                if (trk_prev) trk_hi = trk_len;
                else          trk_lo = trk_len;
                if (trk_len < trk_min) trk_min = trk_len;
            end
            trk_first = 1'b0;
            trk_prev  = div_clk[trk_ch];
            trk_len   = 1;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("div_clk", div_clk, m_out);
        chk("tick", tick, m_tick);
        chk("active", active, act_vec());
        chk("cfg_err", cfg_err, m_err);
        chk("cfg_ready", cfg_ready, exp_ready());
        track();
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        cfg_valid = 1'b0;
        #1;
        chk("rst_div_clk", div_clk, 0);
        chk("rst_tick", tick, 0);
        chk("rst_active", active, 0);
        chk("rst_err", cfg_err, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_active", active, 0);
        rst = 1'b0;
        model_reset();
        #1;
        chk("post_rst_active", active, 3'b111);
    endtask

    task automatic send(input logic [1:0] ch, input int div, input logic en);
        cfg_ch = ch; cfg_div = DivWidth'(div); cfg_en = en; cfg_valid = 1'b1;
        cycle();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_ready(input logic [1:0] ch, output int n);
        cfg_ch = ch;
        #1;
        n = 0;
        while (!cfg_ready && n < 200) begin
            cycle();
            n++;
        end
        chk("wait_ready", cfg_ready, 1);
    endtask

    typedef struct {
        logic [1:0]  ch;
        int          div;
        logic        en;
        logic        exp_ready;
        logic        exp_err;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog cycle %0d: got timeout expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, hi, ticks, last;

        tbl[0] = '{2'd0, 1,  1'b1, 1'b1, 1'b1};
        tbl[1] = '{2'd3, 10, 1'b1, 1'b1, 1'b1};
        tbl[2] = '{2'd1, 0,  1'b0, 1'b1, 1'b0};
        tbl[3] = '{2'd1, 7,  1'b1, 1'b0, 1'b0};
        tbl[4] = '{2'd2, 0,  1'b1, 1'b1, 1'b1};
        tbl[5] = '{2'd2, 1,  1'b0, 1'b1, 1'b0};
        tbl[6] = '{2'd2, 5,  1'b1, 1'b0, 1'b0};
        tbl[7] = '{2'd0, 2,  1'b1, 1'b1, 1'b0};

        // Defaults after reset: ratio 50, first rise on the first edge
        do_reset();
        cycle();
        chk("first_rise", div_clk[0], 1);
        hi = int'(div_clk[0]); ticks = 0; last = -1;
        for (int k = 0; k < 119; k++) begin
            cycle();
            if (k < 49) hi += int'(div_clk[0]);
            if (tick[0]) begin
                if (last >= 0) chk("tick_period_50", cyc - last, 50);
                last = cyc;
                ticks++;
            end
        end
        chk("high_cycles_50", hi, 25);
        chk("ticks_in_120", ticks, 2);

        // Ch1 to ratio 7 while ch0 keeps 50
        send(2'd1, 7, 1'b1);
        wait_ready(2'd1, n);
        trk_reset(1);
        last = -1;
        for (int k = 0; k < 30; k++) begin
            cycle();
            if (tick[1]) begin
                if (last >= 0) chk("tick_period_7", cyc - last, 7);
                last = cyc;
            end
        end
        chk("ch1_high", trk_hi, 4);
        chk("ch1_low", trk_lo, 3);

        // Ratio change 50 -> 10 issued at cnt 20
        do_reset();
        repeat (20) cycle();
        trk_reset(0);
        send(2'd0, 10, 1'b1);
        wait_ready(2'd0, n);
        chk("ready_low_cycles", n, 29);
        repeat (40) cycle();
        chk("ch0_high_10", trk_hi, 5);
        chk("ch0_low_10", trk_lo, 5);
        chk("min_pulse_ge5", trk_min >= 5, 1);

        // Disable, then re-enable at ratio 4
        send(2'd0, 0, 1'b0);
        wait_ready(2'd0, n);
        repeat (3) cycle();
        chk("dis_active", active[0], 0);
        chk("dis_clk", div_clk[0], 0);
        send(2'd0, 4, 1'b1);
        n = 0;
        while (!tick[0] && n < 20) begin
            cycle();
            n++;
        end
        chk("reen_first_tick", n, 5);

        // Reset with an update pending
        send(2'd0, 9, 1'b1);
        chk("pend_ready_low", cfg_ready, 0);
        do_reset();
        chk("rst_ready", cfg_ready, 1);
        ticks = 0;
        repeat (60) begin
            cycle();
            if (tick[0]) ticks++;
        end
        chk("rst_ticks60", ticks, 1);

        // Config table
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cfg_ch = tbl[i].ch; cfg_div = DivWidth'(tbl[i].div); cfg_en = tbl[i].en;
            cfg_valid = 1'b1;
            #1;
            chk("tbl_ready", cfg_ready, tbl[i].exp_ready);
            cycle();
            chk("tbl_err", cfg_err, tbl[i].exp_err);
        end
        cfg_valid = 1'b0;

`ifdef PERIPH_CLK_DIVIDER_SYNC_EN
        do_reset();
        send(2'd0, 6, 1'b1);
        send(2'd1, 3, 1'b1);
        wait_ready(2'd0, n);
        wait_ready(2'd1, n);
        sync = 1'b1;
        cycle();
        sync = 1'b0;
        ticks = 0;
        repeat (36) begin
            cycle();
            if (tick[0]) begin
                chk("sync_align", tick[1], 1);
                ticks++;
            end
        end
        chk("sync_ticks", ticks, 6);
`endif

        // Random traffic against the model
        do_reset();
        for (int k = 0; k < 2500; k++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_ch    = 2'($urandom_range(0, 3));
            cfg_div   = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(0, 300))
                                                    : 16'($urandom_range(0, 12));
            cfg_en    = ($urandom_range(0, 4) != 0);
            cycle();
        end
        cfg_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
